// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA display-timing front end.
// Holds the 640x480@60 defaults, their derived totals and sync windows,
// the packed timing/colour payloads and a window-test helper.
package vga_timing_pkg;

  // 640x480@60 defaults
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned FRAME_W = 8;
  localparam int unsigned PIX_W   = 12;
  localparam int unsigned CH_W    = 4;

  // Sync/valid triple carried through the delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic vld;
  } timing_t;

  // 4:4:4 pixel as produced by the pixel generator
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // True when cnt lies in the half-open window [start, start+width)
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input int unsigned start,
                                     input int unsigned width);
    return (32'(cnt) >= start) && (32'(cnt) < start + width);
  endfunction

endpackage

// File: rtl/vga_timing_pipe_sig_delay.sv
// Fixed-depth register delay line with a parameterised reset value.
// DEPTH=0 is a plain wire (clk/rst then unused).
// Ports: clk, rst (sync, active-high), d in, q = d delayed DEPTH cycles.
module sig_delay #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift register; every stage returns to RST_VAL on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA display-timing front end.
// Generates raster coordinates for the pixel generator, takes back its pixel
// PIPE_DELAY cycles later, and drives aligned sync, valid and blanked RGB.
// Ports:
//   clka, rst            pixel clock, synchronous active-high reset
//   pixel_in[11:0]       {R,G,B} matching coordinates from PIPE_DELAY cycles ago
//   h_cnt, v_cnt         current raster coordinates (registers)
//   hsync, vsync, valid  timing aligned with vga_r/g/b (PIPE_DELAY+1 behind counters)
//   vga_r/g/b            colour, zero outside the active area
//   frame_start          high while counters are at (0,0)
//   frame_cnt            frames completed since reset, wraps at 256
module vga_timing_pipe
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic               clka,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pixel_in,
  output logic [CNT_W-1:0]   h_cnt,
  output logic [CNT_W-1:0]   v_cnt,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [CH_W-1:0]    vga_r,
  output logic [CH_W-1:0]    vga_g,
  output logic [CH_W-1:0]    vga_b,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS      = H_ACTIVE + H_FP;
  localparam int unsigned V_SS      = V_ACTIVE + V_FP;
  localparam timing_t     IDLE      = '{hs: ~SYNC_POL, vs: ~SYNC_POL, vld: 1'b0};

  logic [CNT_W-1:0] h_next, v_next;
  logic             h_wrap, v_wrap;
  timing_t          raw, dly;
  rgb_t             rgb_q;

  // Next raster position
  always_comb begin
    h_wrap = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_wrap = (v_cnt == CNT_W'(V_TOTAL - 1));
    h_next = h_wrap ? '0 : h_cnt + CNT_W'(1);
    v_next = v_cnt;
    if (h_wrap) v_next = v_wrap ? '0 : v_cnt + CNT_W'(1);
  end

  // Counters; frame_start is registered from the next position so it is
  // high exactly while the counters sit at (0,0), including after reset
  always_ff @(posedge clka) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b1;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      frame_start <= (h_next == '0) && (v_next == '0);
      if (h_wrap && v_wrap) frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

  // Raw timing decoded from the current coordinates
  always_comb begin
    raw     = IDLE;
    raw.hs  = in_window(h_cnt, H_SS, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    raw.vs  = in_window(v_cnt, V_SS, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    raw.vld = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
  end

  // Match the pixel generator latency
  sig_delay #(
    .WIDTH   ($bits(timing_t)),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (IDLE)
  ) u_dly (
    .clk (clka),
    .rst (rst),
    .d   (raw),
    .q   (dly)
  );

  // Output register; pixel data only passes during the active area
  always_ff @(posedge clka) begin
    if (rst) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      valid <= 1'b0;
      rgb_q <= '0;
    end else begin
      hsync <= dly.hs;
      vsync <= dly.vs;
      valid <= dly.vld;
      rgb_q <= dly.vld ? rgb_t'(pixel_in) : '0;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule
